// File: rtl/secret_driver.sv
// Stimulus driver and self-checker for the protected secret accumulator block.
// Optional feature macro: SECRET_DRIVER_STOP_ON_ERR_EN (end the test at the first failing cycle).
module secret_driver #(
  parameter int unsigned NUM_CYCLES = 16,
  parameter logic [31:0] SEED       = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] accum_in,
  output logic        accum_bypass,
  input  logic [31:0] accum_out,
  input  logic [31:0] accum_bypass_out,
  output logic [7:0]  s8_in,
  input  logic [7:0]  s8_out,
  output logic [32:0] s33_in,
  input  logic [32:0] s33_out,
  output logic [64:0] s65_in,
  input  logic [64:0] s65_out,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [15:0] LAST_CNT  = 16'(NUM_CYCLES - 32'd1);

  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [2:0] inc);
    logic [8:0] sum;
    sum = {1'b0, base} + 9'(inc);
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  state_t      state_r, state_s;
  logic [31:0] lfsr_r, exp_acc_r, stim_src_s, accum_in_s;
  logic [15:0] cnt_r;
  logic [2:0]  err_inc_s;
  logic [7:0]  err_sum_s, err_s, s8_s;
  logic [32:0] s33_s;
  logic [64:0] s65_s;
  logic        stop_s, bypass_s, done_s, pass_s;

`ifdef SECRET_DRIVER_STOP_ON_ERR_EN
  assign stop_s = (err_inc_s != 3'd0);
`else
  assign stop_s = 1'b0;
`endif

  // Per-cycle error increment: one per failing compare group.
  always_comb begin
    err_inc_s = 3'd0;
    if (state_r == RUN) begin
      err_inc_s = 3'(accum_out != exp_acc_r)
                + 3'(s8_out != s8_in)
                + 3'(s33_out != s33_in)
                + 3'(s65_out != s65_in)
                + 3'(accum_bypass_out != (accum_bypass ? accum_in : exp_acc_r));
    end else if (state_r == CHECK) begin
      err_inc_s = 3'(accum_out != exp_acc_r);
    end else begin
      err_inc_s = 3'd0;
    end
    err_sum_s = sat_add(err_count, err_inc_s);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = SYNC; else state_s = IDLE;
      SYNC:    state_s = RUN;
      RUN: begin
        if (stop_s)                 state_s = DONE;
        else if (cnt_r == LAST_CNT) state_s = CHECK;
        else                        state_s = RUN;
      end
      CHECK:   state_s = DONE;
      DONE:    if (start) state_s = SYNC; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs; stimulus is nonzero only while heading into RUN.
  always_comb begin
    stim_src_s = (state_r == RUN) ? lfsr_step(lfsr_r) : lfsr_r;
    if (state_s == RUN) begin
      accum_in_s = stim_src_s;
      bypass_s   = stim_src_s[31];
      s8_s       = stim_src_s[7:0];
      s33_s      = {stim_src_s[0], stim_src_s};
      s65_s      = {stim_src_s[0], stim_src_s, ~stim_src_s};
    end else begin
      accum_in_s = 32'd0;
      bypass_s   = 1'b0;
      s8_s       = 8'd0;
      s33_s      = 33'd0;
      s65_s      = 65'd0;
    end
    done_s = done;
    pass_s = pass;
    err_s  = err_count;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          done_s = 1'b0;
          pass_s = 1'b0;
          err_s  = 8'd0;
        end else begin
          err_s  = err_count;
        end
      end
      RUN, CHECK: begin
        err_s = err_sum_s;
        if (state_s == DONE) begin
          done_s = 1'b1;
          pass_s = (err_sum_s == 8'd0);
        end else begin
          done_s = done;
        end
      end
      default: err_s = err_count;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accum_in     <= 32'd0;
      accum_bypass <= 1'b0;
      s8_in        <= 8'd0;
      s33_in       <= 33'd0;
      s65_in       <= 65'd0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      accum_in     <= accum_in_s;
      accum_bypass <= bypass_s;
      s8_in        <= s8_s;
      s33_in       <= s33_s;
      s65_in       <= s65_s;
      done         <= done_s;
      pass         <= pass_s;
      err_count    <= err_s;
    end
  end

  // LFSR, reference accumulator and RUN cycle counter; SYNC resyncs to the unreset secret block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r    <= SEED;
      exp_acc_r <= 32'd0;
      cnt_r     <= 16'd0;
    end else begin
      case (state_r)
        IDLE, DONE: if (start) lfsr_r <= SEED;
        SYNC: begin
          exp_acc_r <= accum_out;
          cnt_r     <= 16'd0;
        end
        RUN: begin
          exp_acc_r <= exp_acc_r + accum_in;
          lfsr_r    <= lfsr_step(lfsr_r);
          cnt_r     <= cnt_r + 16'd1;
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_secret_driver.sv
// Scoreboard bench for secret_driver with a behavioural secret accumulator and fault hooks.
module tb_secret_driver;

  localparam int          NC     = 16;
  localparam logic [31:0] SEED_C = 32'h0000_0001;

  typedef struct {
    int         lat;
    logic [7:0] err;
    logic       ps;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start_sat = 1'b0;
  logic [31:0] accum_in, accum_out, accum_bypass_out;
  logic        accum_bypass, done, pass;
  logic [7:0]  s8_in, s8_out, err_count;
  logic [32:0] s33_in, s33_out;
  logic [64:0] s65_in, s65_out;
  logic [31:0] sat_accum_in, sat_bypass_out;
  logic        sat_bypass, sat_done, sat_pass;
  logic [7:0]  sat_s8_in, sat_err;
  logic [32:0] sat_s33_in;
  logic [64:0] sat_s65_in;

  logic [31:0] sec_acc = 32'd0;
  logic        sec_clr = 1'b1;
  logic        force_s33 = 1'b0;
  logic        force_byp = 1'b0;

  int          n_checks = 0;
  int          n_errs = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  logic        done_prev = 1'b0;
  logic [31:0] mon_l;
  res_t        mon_r;
  logic [31:0] stim_q[$];
  res_t        result_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural secret block: no reset, accumulates every cycle.
  always @(posedge clk) begin
    if (sec_clr) sec_acc <= 32'd0;
    else         sec_acc <= sec_acc + accum_in;
  end

  assign accum_out        = sec_acc;
  assign accum_bypass_out = force_byp ? 32'd0 : (accum_bypass ? accum_in : sec_acc);
  assign s8_out           = s8_in;
  assign s33_out          = force_s33 ? {1'b0, s33_in[31:0]} : s33_in;
  assign s65_out          = s65_in;
  assign sat_bypass_out   = sat_bypass ? sat_accum_in : 32'd0;

  secret_driver #(.NUM_CYCLES(NC), .SEED(SEED_C)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .accum_in(accum_in), .accum_bypass(accum_bypass),
    .accum_out(accum_out), .accum_bypass_out(accum_bypass_out),
    .s8_in(s8_in), .s8_out(s8_out), .s33_in(s33_in), .s33_out(s33_out),
    .s65_in(s65_in), .s65_out(s65_out),
    .done(done), .pass(pass), .err_count(err_count)
  );

  secret_driver #(.NUM_CYCLES(300), .SEED(SEED_C)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_sat),
    .accum_in(sat_accum_in), .accum_bypass(sat_bypass),
    .accum_out(32'd0), .accum_bypass_out(sat_bypass_out),
    .s8_in(sat_s8_in), .s8_out(sat_s8_in), .s33_in(sat_s33_in), .s33_out(sat_s33_in),
    .s65_in(sat_s65_in), .s65_out(sat_s65_in),
    .done(sat_done), .pass(sat_pass), .err_count(sat_err)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_nx(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  // mode 0: s33 bit 32 stuck at 0; mode 1: bypass result stuck at 0 with a fresh accumulator.
  function automatic void fault_plan(input int mode, output int nerr, output int first);
    logic [31:0] l;
    logic [31:0] acc;
    logic        bad;
    l = SEED_C; acc = 32'd0; nerr = 0; first = -1;
    for (int i = 0; i < NC; i++) begin
      if (mode == 0) bad = l[0];
      else           bad = l[31] ? 1'b1 : (acc != 32'd0);
      if (bad) begin
        nerr++;
        if (first < 0) first = i;
      end
      acc = acc + l;
      l   = lfsr_nx(l);
    end
  endfunction

  // Stimulus and result monitor: pops the scoreboard as the DUT produces output.
  always @(negedge clk) begin
    if (s65_in != 65'd0) begin
      check_val("stim_avail", 128'(stim_q.size() > 0), 128'd1);
      if (stim_q.size() > 0) begin
        mon_l = stim_q.pop_front();
        check_val("accum_in", 128'(accum_in), 128'(mon_l));
        check_val("accum_bypass", 128'(accum_bypass), 128'(mon_l[31]));
        check_val("s8_in", 128'(s8_in), 128'(mon_l[7:0]));
        check_val("s33_in", 128'(s33_in), 128'({mon_l[0], mon_l}));
        check_val("s65_in", 128'(s65_in), 128'({mon_l[0], mon_l, ~mon_l}));
      end
    end
    if (done && !done_prev) begin
      check_val("result_avail", 128'(result_q.size() > 0), 128'd1);
      if (result_q.size() > 0) begin
        mon_r = result_q.pop_front();
        check_val("done_latency", 128'(cyc - start_cyc), 128'(mon_r.lat));
        check_val("err_count", 128'(err_count), 128'(mon_r.err));
        check_val("pass", 128'(pass), 128'(mon_r.ps));
      end
    end
    done_prev = done;
  end

  task automatic kick(input int n_stim, input bit push_res, input int lat,
                      input logic [7:0] err, input logic ps);
    res_t        r;
    logic [31:0] l;
    if (push_res) begin
      r.lat = lat; r.err = err; r.ps = ps;
      result_q.push_back(r);
    end
    l = SEED_C;
    for (int i = 0; i < n_stim; i++) begin
      stim_q.push_back(l);
      l = lfsr_nx(l);
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; start_cyc = cyc;
  endtask

  task automatic wait_result(input int budget);
    int k;
    k = 0;
    while (result_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val("result_pending", 128'(result_q.size()), 128'd0);
    check_val("stim_pending", 128'(stim_q.size()), 128'd0);
    result_q.delete();
    stim_q.delete();
  endtask

  task automatic fault_run(input int mode);
    int nerr, first;
    fault_plan(mode, nerr, first);
`ifdef SECRET_DRIVER_STOP_ON_ERR_EN
    if (first >= 0) kick(first + 1, 1'b1, first + 2, 8'd1, 1'b0);
    else            kick(NC, 1'b1, NC + 2, 8'd0, 1'b1);
`else
    kick(NC, 1'b1, NC + 2, 8'(nerr), (nerr == 0));
`endif
    wait_result(100);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_accum_in", 128'(accum_in), 128'd0);
    check_val("rst_s65_in", 128'(s65_in), 128'd0);
    check_val("rst_done", 128'(done), 128'd0);
    check_val("rst_pass", 128'(pass), 128'd0);
    check_val("rst_err", 128'(err_count), 128'd0);
    rst_n = 1'b1;
    @(negedge clk); sec_clr = 1'b0;

    // Clean run from a fresh accumulator, with the known first accumulator values.
    kick(NC, 1'b1, NC + 2, 8'd0, 1'b1);
    repeat (2) @(negedge clk);
    check_val("acc_after_c1", 128'(accum_out), 128'h0000_0001);
    check_val("bypass_c2", 128'(accum_bypass_out), 128'h8020_0003);
    @(negedge clk);
    check_val("acc_after_c2", 128'(accum_out), 128'h8020_0004);
    wait_result(100);

    // Back-to-back from DONE: resync to the nonzero retained accumulator.
    kick(NC, 1'b1, NC + 2, 8'd0, 1'b1);
    wait_result(100);

    force_s33 = 1'b1;
    fault_run(0);
    force_s33 = 1'b0;

    // Reset during RUN cycle 5.
    kick(5, 1'b0, 0, 8'd0, 1'b0);
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_val("midrst_accum_in", 128'(accum_in), 128'd0);
    check_val("midrst_s65_in", 128'(s65_in), 128'd0);
    check_val("midrst_done", 128'(done), 128'd0);
    check_val("midrst_err", 128'(err_count), 128'd0);
    check_val("midrst_stim_left", 128'(stim_q.size()), 128'd0);
    stim_q.delete();
    @(negedge clk); rst_n = 1'b1;
    kick(NC, 1'b1, NC + 2, 8'd0, 1'b1);
    wait_result(100);

    @(negedge clk); sec_clr = 1'b1;
    @(negedge clk); sec_clr = 1'b0;
    force_byp = 1'b1;
    fault_run(1);
    force_byp = 1'b0;

    // Saturation instance sees a stuck-at-0 accumulator.
    @(negedge clk); start_sat = 1'b1;
    @(negedge clk); start_sat = 1'b0;
    for (int i = 0; i < 400 && !sat_done; i++) @(negedge clk);
    check_val("sat_done", 128'(sat_done), 128'd1);
`ifdef SECRET_DRIVER_STOP_ON_ERR_EN
    check_val("sat_err", 128'(sat_err), 128'd1);
`else
    check_val("sat_err", 128'(sat_err), 128'd255);
`endif
    check_val("sat_pass", 128'(sat_pass), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
